// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes each complete 32-bit SPI frame into a register write
// or read for the quad stepper, and latches the response word that the SPI
// slave shifts out during the next CS frame.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   cs           raw chip select (active low), synchronised internally
//   rx_data      received frame; rx_ready is the frame-complete level
//   tx_data      response word, loaded by the slave at CS fall
//   velocity     per-axis signed velocity, axis i at [i*VEL_W +: VEL_W]
//   axis_en      per-axis enable
//   vel_update   one-cycle pulse per axis when its velocity is written
//   pos_in       per-axis position from the step generators
//   err_count    saturating count of bad commands and short frames
module spi_cmd_ctrl #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned NUM_AXES = 4,
    parameter int unsigned VEL_W    = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs,
    input  logic [DATA_LEN-1:0]       rx_data,
    input  logic                      rx_ready,
    output logic [DATA_LEN-1:0]       tx_data,
    output logic [NUM_AXES*VEL_W-1:0] velocity,
    output logic [NUM_AXES-1:0]       axis_en,
    output logic [NUM_AXES-1:0]       vel_update,
    input  logic [NUM_AXES*VEL_W-1:0] pos_in,
    output logic [7:0]                err_count
);

    localparam int unsigned SEQ_W = 4;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned FLD_W = 24;
    localparam logic [3:0]  OP_NOP   = 4'h0;
    localparam logic [3:0]  OP_WR    = 4'h1;
    localparam logic [3:0]  OP_RD    = 4'h2;
    localparam logic [3:0]  ADDR_EN  = 4'h8;
    localparam logic [3:0]  ADDR_POS = 4'hC;

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_EXEC, ST_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_cs_s1, r_cs_s2, r_cs_d;
    logic                  r_rdy, r_rdy_d;
    logic                  r_got_frame;
    logic [DATA_LEN-1:0]   r_cmd;
    logic [SEQ_W-1:0]      r_seq;
    logic [ERR_W-1:0]      r_err_cnt;
    logic [DATA_LEN-1:0]   r_tx;
    logic [VEL_W-1:0]      r_vel [NUM_AXES];
    logic [NUM_AXES-1:0]   r_en;
    logic [NUM_AXES-1:0]   r_vel_upd;

    logic                  w_cs_rise, w_cs_fall, w_rdy_rise;
    logic [3:0]            w_op, w_addr;
    logic [FLD_W-1:0]      w_data;
    logic                  w_latch, w_short, w_exec, w_err, w_en_we;
    logic [NUM_AXES-1:0]   w_vel_we;
    logic [FLD_W-1:0]      w_rsp;

    assign w_cs_rise  = r_cs_s2 & ~r_cs_d;
    assign w_cs_fall  = ~r_cs_s2 & r_cs_d;
    assign w_rdy_rise = r_rdy & ~r_rdy_d;
    assign w_op       = r_cmd[31:28];
    assign w_addr     = r_cmd[27:24];
    assign w_data     = r_cmd[23:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_SYNC;
        else        r_state <= w_next;
    end

    // Next state, frame qualification and command decode
    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_short  = 1'b0;
        w_exec   = 1'b0;
        w_err    = 1'b0;
        w_en_we  = 1'b0;
        w_vel_we = '0;
        w_rsp    = '0;
        unique case (r_state)
            ST_SYNC: if (r_cs_s2) w_next = ST_IDLE;
            ST_IDLE: begin
                if (w_rdy_rise) begin
                    w_next  = ST_EXEC;
                    w_latch = 1'b1;
                end else if (w_cs_rise && !r_got_frame) begin
                    w_short = 1'b1;
                end
            end
            ST_EXEC: begin
                w_next = ST_DONE;
                w_exec = 1'b1;
                unique case (w_op)
                    OP_NOP: ;
                    OP_WR: begin
                        if (w_addr == ADDR_EN) begin
                            w_en_we = 1'b1;
                        end else begin
                            w_err = 1'b1;
                            for (int i = 0; i < NUM_AXES; i++) begin
                                if (w_addr == 4'(i)) begin
                                    w_vel_we[i] = 1'b1;
                                    w_err       = 1'b0;
                                end
                            end
                        end
                    end
                    OP_RD: begin
                        if (w_addr == ADDR_EN) begin
                            w_rsp = FLD_W'(r_en);
                        end else begin
                            w_err = 1'b1;
                            for (int i = 0; i < NUM_AXES; i++) begin
                                if (w_addr == 4'(i)) begin
                                    w_rsp = FLD_W'(r_vel[i]);
                                    w_err = 1'b0;
                                end
                                if (w_addr == 4'(ADDR_POS + 4'(i))) begin
                                    w_rsp = FLD_W'(pos_in[i*VEL_W +: VEL_W]);
                                    w_err = 1'b0;
                                end
                            end
                        end
                    end
                    default: w_err = 1'b1;
                endcase
            end
            ST_DONE: if (r_cs_s2) w_next = ST_IDLE;
            default: w_next = ST_SYNC;
        endcase
    end

    // CS synchroniser and edge-detect pipelines; sync flops reset low so a
    // frame in progress at reset release is held off until CS really rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_s1 <= 1'b0;
            r_cs_s2 <= 1'b0;
            r_cs_d  <= 1'b0;
            r_rdy   <= 1'b0;
            r_rdy_d <= 1'b0;
        end else begin
            r_cs_s1 <= cs;
            r_cs_s2 <= r_cs_s1;
            r_cs_d  <= r_cs_s2;
            r_rdy   <= rx_ready;
            r_rdy_d <= r_rdy;
        end
    end

    // Command latch, register file, response word and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_got_frame <= 1'b0;
            r_cmd       <= '0;
            r_seq       <= '0;
            r_err_cnt   <= '0;
            r_tx        <= '0;
            r_en        <= '0;
            r_vel_upd   <= '0;
            for (int i = 0; i < NUM_AXES; i++) r_vel[i] <= '0;
        end else begin
            r_vel_upd <= w_vel_we;
            if (w_cs_fall)    r_got_frame <= 1'b0;
            else if (w_latch) r_got_frame <= 1'b1;
            if (w_latch) r_cmd <= rx_data;
            if (w_exec) begin
                r_tx  <= {r_seq, w_err, w_op[2:0], w_rsp};
                r_seq <= r_seq + SEQ_W'(1);
            end
            for (int i = 0; i < NUM_AXES; i++) begin
                if (w_vel_we[i]) r_vel[i] <= w_data[VEL_W-1:0];
            end
            if (w_en_we) r_en <= w_data[NUM_AXES-1:0];
            if ((w_short || w_err) && (r_err_cnt != {ERR_W{1'b1}}))
                r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_AXES; g++) begin : g_vel
        assign velocity[g*VEL_W +: VEL_W] = r_vel[g];
    end

    assign tx_data    = r_tx;
    assign axis_en    = r_en;
    assign vel_update = r_vel_upd;
    assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: frame-level stimulus with a behavioural model
// of the register file, response word, sequence and error counters.
module tb_spi_cmd_ctrl;

    localparam int unsigned NA = 4;
    localparam int unsigned VW = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cs;
    logic [31:0]       rx_data;
    logic              rx_ready;
    logic [31:0]       tx_data;
    logic [NA*VW-1:0]  velocity;
    logic [NA-1:0]     axis_en;
    logic [NA-1:0]     vel_update;
    logic [NA*VW-1:0]  pos_in;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.DATA_LEN(32), .NUM_AXES(NA), .VEL_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rx_data(rx_data),
        .rx_ready(rx_ready), .tx_data(tx_data), .velocity(velocity),
        .axis_en(axis_en), .vel_update(vel_update), .pos_in(pos_in),
        .err_count(err_count)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    // behavioural model state
    logic [23:0] m_vel [NA];
    logic [3:0]  m_en, m_upd, m_seq;
    logic [7:0]  m_err;
    logic [31:0] m_tx;
    logic [3:0]  snap_upd;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NA; i++) m_vel[i] = '0;
        m_en = '0; m_upd = '0; m_seq = '0; m_err = '0; m_tx = '0;
    endfunction

    function automatic void m_err_inc();
        if (m_err < 8'd255) m_err = m_err + 8'd1;
    endfunction

    function automatic logic [NA*VW-1:0] m_vel_vec();
        logic [NA*VW-1:0] v;
        for (int i = 0; i < NA; i++) v[i*VW +: VW] = m_vel[i];
        return v;
    endfunction

    // Command semantics straight from the register map
    function automatic void m_exec(logic [31:0] cmd);
        int unsigned op, addr;
        logic [23:0] data, rd;
        bit err;
        op = int'(cmd >> 28); addr = int'((cmd >> 24) & 32'hF); data = cmd[23:0];
        rd = '0; err = 1'b0;
        if (op == 0) begin
        end else if (op == 1) begin
            if (addr < NA) begin m_vel[addr] = data; m_upd[addr] = 1'b1; end
            else if (addr == 8) m_en = data[3:0];
            else err = 1'b1;
        end else if (op == 2) begin
            if (addr < NA) rd = m_vel[addr];
            else if (addr == 8) rd = {20'd0, m_en};
            else if (addr >= 12 && addr < 12 + NA) rd = pos_in[(addr-12)*VW +: VW];
            else err = 1'b1;
        end else err = 1'b1;
        m_tx  = {m_seq, err, 3'(op), rd};
        m_seq = m_seq + 4'd1;
        if (err) m_err_inc();
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("velocity",   128'(velocity),   128'(m_vel_vec()));
            check("axis_en",    128'(axis_en),    128'(m_en));
            check("vel_update", 128'(vel_update), 128'(m_upd));
            check("tx_data",    128'(tx_data),    128'(m_tx));
            check("err_count",  128'(err_count),  128'(m_err));
        end
    end

    // Full 32-bit frame; result appears two edges after rx_ready is sampled
    task automatic do_frame(input logic [31:0] cmd);
        @(negedge clk) cs = 1'b0;
        repeat (4) @(negedge clk);
        rx_data = cmd; rx_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        m_exec(cmd);
        snap_upd = vel_update;
        @(posedge clk); #1;
        m_upd = '0;
        repeat (2) @(negedge clk);
        cs = 1'b1; rx_ready = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // CS pulse with no completed frame
    task automatic short_frame(input int n);
        @(negedge clk) cs = 1'b0;
        repeat (n) @(negedge clk);
        cs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        m_err_inc();
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [3:0] op, addr;
        int unsigned r;
        r = $urandom_range(0, 9);
        op = (r < 3) ? 4'h1 : (r < 6) ? 4'h2 : (r < 8) ? 4'h0 : 4'($urandom_range(3, 15));
        r = $urandom_range(0, 7);
        addr = (r == 0) ? 4'h8 : (r < 3) ? 4'($urandom_range(0, 3)) :
               (r == 3) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 15));
        return {op, addr, 24'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0; cs = 1'b1; rx_ready = 1'b0; rx_data = '0; pos_in = '0;
        snap_upd = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_tx",  128'(tx_data),   128'(0));
        check("rst_vel", 128'(velocity),  128'(0));
        check("rst_en",  128'(axis_en),   128'(0));
        check("rst_upd", 128'(vel_update),128'(0));
        check("rst_err", 128'(err_count), 128'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_en = 1'b1;

        // basic write
        do_frame(32'h1000_0123);
        check("t1_tx",   128'(tx_data),        128'(32'h0100_0000));
        check("t1_vel0", 128'(velocity[23:0]), 128'(24'h000123));
        check("t1_upd",  128'(snap_upd),       128'(4'b0001));

        // enable write then read-back
        do_frame(32'h1880_000F);
        check("t2_en", 128'(axis_en), 128'(4'hF));
        do_frame(32'h2800_0000);
        check("t2_tx", 128'(tx_data), 128'(32'h2200_000F));

        // position read of axis 2
        pos_in = '0;
        pos_in[2*VW +: VW] = 24'hFFFFFE;
        do_frame(32'h2E00_0000);
        check("t3_tx", 128'(tx_data), 128'(32'h32FF_FFFE));

        // bad opcode, bad address
        do_frame(32'h7000_0000);
        check("t4a_tx", 128'(tx_data), 128'(32'h4F00_0000));
        do_frame(32'h1500_0001);
        check("t4b_tx",  128'(tx_data),   128'(32'h5900_0000));
        check("t4_err",  128'(err_count), 128'(8'd2));
        check("t4_vel",  128'(velocity),  128'(96'h000123));

        // short frame
        short_frame(6);
        check("t5_err", 128'(err_count), 128'(8'd3));

        // reset mid-frame; the frame completing afterwards is discarded
        @(negedge clk) cs = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0; m_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_data = 32'h1000_0555; rx_ready = 1'b1;
        repeat (6) @(negedge clk);
        cs = 1'b1; rx_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("t5r_vel", 128'(velocity),  128'(0));
        check("t5r_tx",  128'(tx_data),   128'(0));
        check("t5r_err", 128'(err_count), 128'(0));

        // seq wrap
        for (int i = 0; i < 16; i++) do_frame(32'h0000_0000);
        check("t6_seq15", 128'(tx_data), 128'(32'hF000_0000));
        do_frame(32'h0000_0000);
        check("t6_seq0",  128'(tx_data), 128'(32'h0000_0000));

        // random traffic
        for (int i = 0; i < 150; i++) begin
            pos_in = {32'($urandom), 32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 9) == 0) short_frame(int'($urandom_range(3, 8)));
            else do_frame(rand_cmd());
        end

        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) short_frame(4);
            else do_frame(32'h9000_0000);
        end
        check("t6_sat", 128'(err_count), 128'(8'd255));

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
